// File: rtl/vanilla_id_scoreboard_pkg.sv
// Shared types and constants for the vanilla core ID-stage scoreboard.
//   RV32_reg_els_gp   : number of architectural integer registers
//   reg_addr_width_gp : register id width
//   instruction_s     : raw RV32 instruction fields (rs1, rs2, rd used here)
//   decode_s          : decoder outputs (read_rs1, read_rs2, write_rd used here)
package vanilla_id_scoreboard_pkg;

    localparam int unsigned RV32_reg_els_gp   = 32;
    localparam int unsigned reg_addr_width_gp = 5;

    typedef struct packed {
        logic [6:0]                   funct7;
        logic [reg_addr_width_gp-1:0] rs2;
        logic [reg_addr_width_gp-1:0] rs1;
        logic [2:0]                   funct3;
        logic [reg_addr_width_gp-1:0] rd;
        logic [6:0]                   op;
    } instruction_s;

    typedef struct packed {
        logic write_rd;
        logic read_rs1;
        logic read_rs2;
        logic is_load_op;
        logic is_idiv_op;
        logic is_amo_op;
    } decode_s;

endpackage

// File: rtl/vanilla_id_scoreboard_if.sv
// ID-stage / scoreboard signal bundle.
//   master : ID stage side (drives instruction, decode, score, flush, clears)
//   slave  : scoreboard side (drives dependency_o, pending_cnt_o, clear_err_o)
// Optional stall statistics (stall_cnt_o, last_stall_reg_o) exist only when
// VANILLA_SCOREBOARD_STALL_STATS_EN is defined.
interface vanilla_id_scoreboard_if
    import vanilla_id_scoreboard_pkg::*;
#(
    parameter int unsigned els_p            = RV32_reg_els_gp,
    parameter int unsigned num_clear_port_p = 2
);
    localparam int unsigned reg_addr_width_lp = $clog2(els_p);
    localparam int unsigned cnt_width_lp      = $clog2(els_p + 1);

    instruction_s                                        instruction_i;
    decode_s                                             decode_i;
    logic                                                id_v_i;
    logic                                                score_i;
    logic                                                flush_i;
    logic [num_clear_port_p-1:0]                         clear_i;
    logic [num_clear_port_p-1:0][reg_addr_width_lp-1:0] clear_id_i;
    logic                                                dependency_o;
    logic [cnt_width_lp-1:0]                             pending_cnt_o;
    logic                                                clear_err_o;
`ifdef VANILLA_SCOREBOARD_STALL_STATS_EN
    logic [31:0]                                         stall_cnt_o;
    logic [reg_addr_width_lp-1:0]                        last_stall_reg_o;
`endif

    modport master (
        output instruction_i, decode_i, id_v_i, score_i, flush_i, clear_i, clear_id_i,
        input  dependency_o, pending_cnt_o, clear_err_o
`ifdef VANILLA_SCOREBOARD_STALL_STATS_EN
        , input stall_cnt_o, last_stall_reg_o
`endif
    );

    modport slave (
        input  instruction_i, decode_i, id_v_i, score_i, flush_i, clear_i, clear_id_i,
        output dependency_o, pending_cnt_o, clear_err_o
`ifdef VANILLA_SCOREBOARD_STALL_STATS_EN
        , output stall_cnt_o, last_stall_reg_o
`endif
    );

endinterface

// File: rtl/vanilla_id_scoreboard_decode_with_v.sv
// One-hot decoder with valid: o has bit i set when v_i, otherwise all zero.
//   i   : index to decode
//   v_i : enable
//   o   : one-hot result
module vanilla_id_scoreboard_decode_with_v #(
    parameter int unsigned num_out_p = 32
) (
    input  logic [$clog2(num_out_p)-1:0] i,
    input  logic                         v_i,
    output logic [num_out_p-1:0]         o
);
    localparam int unsigned sel_width_lp = $clog2(num_out_p);

    always_comb begin
        o = '0;
        for (int unsigned k = 0; k < num_out_p; k++) begin
            o[k] = v_i && (i == sel_width_lp'(k));
        end
    end

endmodule

// File: rtl/vanilla_id_scoreboard.sv
// ID-stage scoreboard for long-latency integer writebacks (remote loads,
// idiv, AMO). Raises a same-cycle dependency stall on RAW/WAW against any
// pending register, with current-cycle clears bypassed.
//   clk_i, reset_i : clock, synchronous active-high reset
//   sb (slave)     : instruction/decode/score/flush/clear inputs;
//                    dependency_o (comb), pending_cnt_o, clear_err_o (registered)
// Optional: VANILLA_SCOREBOARD_STALL_STATS_EN adds stall_cnt_o and
// last_stall_reg_o.
module vanilla_id_scoreboard
    import vanilla_id_scoreboard_pkg::*;
#(
    parameter int unsigned els_p             = RV32_reg_els_gp,
    parameter int unsigned num_clear_port_p  = 2,
    parameter bit          x0_tied_to_zero_p = 1'b1
) (
    input logic               clk_i,
    input logic               reset_i,
    vanilla_id_scoreboard_if.slave sb
);
    localparam int unsigned reg_addr_width_lp = $clog2(els_p);
    localparam int unsigned cnt_width_lp      = $clog2(els_p + 1);

    logic [els_p-1:0]             scoreboard_r, scoreboard_n;
    logic [els_p-1:0]             clear_mask;
    logic [els_p-1:0]             score_mask;
    logic [els_p-1:0]             clear_decode [num_clear_port_p];
    logic [cnt_width_lp-1:0]      pending_cnt_r, pending_cnt_n;
    logic                         clear_err_r, clear_err_n;
    logic [reg_addr_width_lp-1:0] rs1, rs2, rd;
    logic                         score_v;
    logic                         rs1_dep, rs2_dep, waw_dep;

    assign rs1 = reg_addr_width_lp'(sb.instruction_i.rs1);
    assign rs2 = reg_addr_width_lp'(sb.instruction_i.rs2);
    assign rd  = reg_addr_width_lp'(sb.instruction_i.rd);

    // Fields carried by the shared structs that this stage does not need.
    logic unused_fields;
    assign unused_fields = ^{sb.instruction_i.funct7, sb.instruction_i.funct3,
                             sb.instruction_i.op, sb.decode_i.is_load_op,
                             sb.decode_i.is_idiv_op, sb.decode_i.is_amo_op};

    // Per-port clear decode, OR-reduced; duplicate ids collapse to one bit.
    for (genvar p = 0; p < num_clear_port_p; p++) begin : g_clear_dec
        vanilla_id_scoreboard_decode_with_v #(
            .num_out_p (els_p)
        ) u_dec (
            .i   (sb.clear_id_i[p]),
            .v_i (sb.clear_i[p]),
            .o   (clear_decode[p])
        );
    end

    always_comb begin
        clear_mask = '0;
        for (int unsigned p = 0; p < num_clear_port_p; p++) begin
            clear_mask = clear_mask | clear_decode[p];
        end
    end

    function automatic logic is_x0(input logic [reg_addr_width_lp-1:0] addr);
        return x0_tied_to_zero_p && (addr == '0);
    endfunction

    // Score/clear next state; score is applied after clear so it wins on a tie.
    always_comb begin
        score_v      = sb.id_v_i && sb.score_i && !sb.flush_i
                       && sb.decode_i.write_rd && !is_x0(rd);
        score_mask   = score_v ? (els_p'(1) << rd) : '0;
        scoreboard_n = (scoreboard_r & ~clear_mask) | score_mask;

        pending_cnt_n = '0;
        for (int unsigned k = 0; k < els_p; k++) begin
            pending_cnt_n = pending_cnt_n + cnt_width_lp'(scoreboard_n[k]);
        end

        clear_err_n = 1'b0;
        for (int unsigned p = 0; p < num_clear_port_p; p++) begin
            if (sb.clear_i[p] && !scoreboard_r[sb.clear_id_i[p]]) begin
                clear_err_n = 1'b1;
            end
        end
    end

    // Hazard detection with same-cycle clear bypass.
    always_comb begin
        rs1_dep = sb.decode_i.read_rs1 && scoreboard_r[rs1] && !clear_mask[rs1] && !is_x0(rs1);
        rs2_dep = sb.decode_i.read_rs2 && scoreboard_r[rs2] && !clear_mask[rs2] && !is_x0(rs2);
        waw_dep = sb.decode_i.write_rd && scoreboard_r[rd]  && !clear_mask[rd]  && !is_x0(rd);
    end

    assign sb.dependency_o = sb.id_v_i && (rs1_dep || rs2_dep || waw_dep);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            scoreboard_r  <= '0;
            pending_cnt_r <= '0;
            clear_err_r   <= 1'b0;
        end else begin
            scoreboard_r  <= scoreboard_n;
            pending_cnt_r <= pending_cnt_n;
            clear_err_r   <= clear_err_n;
        end
    end

    assign sb.pending_cnt_o = pending_cnt_r;
    assign sb.clear_err_o   = clear_err_r;

`ifdef VANILLA_SCOREBOARD_STALL_STATS_EN
    logic [31:0]                  stall_cnt_r;
    logic [reg_addr_width_lp-1:0] last_stall_reg_r;
    logic [reg_addr_width_lp-1:0] stall_reg;

    // Blocking register priority: rs1, then rs2, then rd.
    always_comb begin
        stall_reg = rd;
        if (rs1_dep) begin
            stall_reg = rs1;
        end else if (rs2_dep) begin
            stall_reg = rs2;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_r      <= '0;
            last_stall_reg_r <= '0;
        end else if (sb.dependency_o) begin
            stall_cnt_r      <= stall_cnt_r + 32'd1;
            last_stall_reg_r <= stall_reg;
        end
    end

    assign sb.stall_cnt_o      = stall_cnt_r;
    assign sb.last_stall_reg_o = last_stall_reg_r;
`endif

    // Issuing a new long-latency writer while stalled would corrupt tracking.
    score_while_stalled_a: assert property (
        @(posedge clk_i) disable iff (reset_i) !(sb.score_i && sb.dependency_o));

endmodule

// File: tb/tb_vanilla_id_scoreboard.sv
// Directed bench for vanilla_id_scoreboard with hand-computed expectations.
module tb_vanilla_id_scoreboard;
    import vanilla_id_scoreboard_pkg::*;

    logic clk;
    logic reset;
    int   tests;
    int   failed;

    vanilla_id_scoreboard_if #(.els_p(32), .num_clear_port_p(2)) sb_if ();

    vanilla_id_scoreboard #(
        .els_p             (32),
        .num_clear_port_p  (2),
        .x0_tied_to_zero_p (1'b1)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .sb      (sb_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int rs1, input int rs2, input int rd,
                         input logic rr1, input logic rr2, input logic wrd,
                         input logic sc, input logic fl);
        sb_if.instruction_i     = '0;
        sb_if.instruction_i.rs1 = 5'(rs1);
        sb_if.instruction_i.rs2 = 5'(rs2);
        sb_if.instruction_i.rd  = 5'(rd);
        sb_if.decode_i          = '0;
        sb_if.decode_i.read_rs1 = rr1;
        sb_if.decode_i.read_rs2 = rr2;
        sb_if.decode_i.write_rd = wrd;
        sb_if.id_v_i            = v;
        sb_if.score_i           = sc;
        sb_if.flush_i           = fl;
    endtask

    task automatic set_clear(input logic v0, input int id0, input logic v1, input int id1);
        sb_if.clear_i       = {v1, v0};
        sb_if.clear_id_i[0] = 5'(id0);
        sb_if.clear_id_i[1] = 5'(id1);
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        clk    = 1'b0;
        reset  = 1'b1;
        tests  = 0;
        failed = 0;
        idle();
        set_clear(1'b0, 0, 1'b0, 0);
        tick();
        tick();
        check("reset_pending", 32'(sb_if.pending_cnt_o), 0);
        check("reset_err", 32'(sb_if.clear_err_o), 0);
        check("reset_dep", 32'(sb_if.dependency_o), 0);
        reset = 1'b0;

        // add x3,x1,x2 with nothing pending
        drive(1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 check("add_no_dep", 32'(sb_if.dependency_o), 0);
        tick();
        check("add_pending", 32'(sb_if.pending_cnt_o), 0);

        // lw x5 scores
        drive(1'b1, 1, 0, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        #1 check("lw5_dep", 32'(sb_if.dependency_o), 0);
        tick();
        check("lw5_pending", 32'(sb_if.pending_cnt_o), 1);

        // add x6,x5,x0: RAW stall, then bypassed by a same-cycle clear
        drive(1'b1, 5, 0, 6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 check("raw_rs1", 32'(sb_if.dependency_o), 1);
        set_clear(1'b1, 5, 1'b0, 0);
        #1 check("raw_bypass", 32'(sb_if.dependency_o), 0);
        tick();
        check("raw_clr_pending", 32'(sb_if.pending_cnt_o), 0);
        check("raw_clr_err", 32'(sb_if.clear_err_o), 0);
        set_clear(1'b0, 0, 1'b0, 0);

        // rd=7 scored, then rescored with a same-cycle clear of 7
        drive(1'b1, 0, 0, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check("s7_pending", 32'(sb_if.pending_cnt_o), 1);
        set_clear(1'b1, 7, 1'b0, 0);
        #1 check("s7_waw_bypass", 32'(sb_if.dependency_o), 0);
        tick();
        check("s7_rescore_pending", 32'(sb_if.pending_cnt_o), 1);
        check("s7_rescore_err", 32'(sb_if.clear_err_o), 0);
        idle();
        set_clear(1'b0, 0, 1'b1, 7);
        tick();
        check("s7_retire_pending", 32'(sb_if.pending_cnt_o), 0);
        check("s7_retire_err", 32'(sb_if.clear_err_o), 0);
        set_clear(1'b0, 0, 1'b0, 0);

        // both ports clear id 9
        drive(1'b1, 0, 0, 9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check("s9_pending", 32'(sb_if.pending_cnt_o), 1);
        idle();
        set_clear(1'b1, 9, 1'b1, 9);
        tick();
        check("dual_clr_pending", 32'(sb_if.pending_cnt_o), 0);
        check("dual_clr_err", 32'(sb_if.clear_err_o), 0);
        set_clear(1'b0, 0, 1'b0, 0);

        // x0 and flushed scores are ignored
        drive(1'b1, 0, 0, 11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check("s11_pending", 32'(sb_if.pending_cnt_o), 1);
        drive(1'b1, 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 check("x0_dep", 32'(sb_if.dependency_o), 0);
        tick();
        check("x0_pending", 32'(sb_if.pending_cnt_o), 1);
        drive(1'b1, 0, 0, 4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        check("flush_pending", 32'(sb_if.pending_cnt_o), 1);

        // spurious clear of id 12
        idle();
        set_clear(1'b0, 0, 1'b1, 12);
        tick();
        check("spur_err", 32'(sb_if.clear_err_o), 1);
        check("spur_pending", 32'(sb_if.pending_cnt_o), 1);
        set_clear(1'b0, 0, 1'b0, 0);
        tick();
        check("spur_err_drop", 32'(sb_if.clear_err_o), 0);

        // WAW stall on x10 held for three cycles
        drive(1'b1, 0, 0, 10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check("s10_pending", 32'(sb_if.pending_cnt_o), 2);
        drive(1'b1, 1, 0, 10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 check("waw_dep", 32'(sb_if.dependency_o), 1);
        tick();
        tick();
        tick();
        check("waw_dep_held", 32'(sb_if.dependency_o), 1);
`ifdef VANILLA_SCOREBOARD_STALL_STATS_EN
        check("stall_cnt3", sb_if.stall_cnt_o, 3);
        check("last_reg10", 32'(sb_if.last_stall_reg_o), 10);
`endif
        // rs1 on x11 outranks the WAW on x10
        drive(1'b1, 11, 0, 10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
`ifdef VANILLA_SCOREBOARD_STALL_STATS_EN
        check("stall_cnt4", sb_if.stall_cnt_o, 4);
        check("last_reg11", 32'(sb_if.last_stall_reg_o), 11);
`endif
        drive(1'b0, 11, 0, 10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 check("idv_mask", 32'(sb_if.dependency_o), 0);
        drive(1'b1, 0, 11, 12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 check("rs2_noread", 32'(sb_if.dependency_o), 0);
        drive(1'b1, 0, 11, 12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 check("rs2_dep", 32'(sb_if.dependency_o), 1);

        // reset mid-operation drops x10 and x11
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_pending", 32'(sb_if.pending_cnt_o), 0);
        check("rst2_err", 32'(sb_if.clear_err_o), 0);
`ifdef VANILLA_SCOREBOARD_STALL_STATS_EN
        check("rst2_stall_cnt", sb_if.stall_cnt_o, 0);
`endif
        set_clear(1'b1, 10, 1'b0, 0);
        tick();
        check("rst2_late_clr_err", 32'(sb_if.clear_err_o), 1);
        check("rst2_late_clr_pending", 32'(sb_if.pending_cnt_o), 0);
        set_clear(1'b0, 0, 1'b0, 0);
        drive(1'b1, 11, 0, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 check("rst2_dep", 32'(sb_if.dependency_o), 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
